any1_fetch_seq: RTL and testbench

- Instruction-fetch sequencer that sits between the I-cache and the instruction aligner.
- Keeps a two-line window: the current line plus the next sequential line.
- Steps the instruction pointer by each decoded instruction length and prefetches the following line whenever execution crosses a line boundary.
- Handles branch redirects, including redirects that arrive while a cache request is outstanding.

---
 rtl/any1_fetch_seq.sv | 202 ++++++++++++++++++++
 tb/tb_any1_fetch_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/any1_fetch_seq.sv
// Instruction-fetch sequencer: keeps a two-line window (current + next sequential line)
// for the aligner, steps the IP by instruction length and handles branch redirects.
module any1_fetch_seq #(
  parameter logic [31:0] RESET_IP = 32'hFFFC0000,
  parameter int unsigned LINE_W   = 512
) (
  input  logic                rst_i,
  input  logic                clk_i,
  input  logic                redirect_i,
  input  logic [31:0]         redirect_ip_i,
  output logic                ic_req_o,
  output logic [25:0]         ic_adr_o,
  input  logic                ic_ack_i,
  input  logic [LINE_W-1:0]   ic_line_i,
  output logic                al_v_o,
  output logic [2*LINE_W-1:0] al_window_o,
  output logic [31:0]         al_ip_o,
  output logic [5:0]          al_ofs_o,
  input  logic [3:0]          al_len_i,
  input  logic                al_rdy_i
);

  typedef enum logic [1:0] {
    FETCH0 = 2'd0,
    FETCH1 = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [31:0]         ip_r, ip_s;
  logic [LINE_W-1:0]   line0_r, line0_s;
  logic [LINE_W-1:0]   line1_r, line1_s;
  logic                line0_v_r, line0_v_s;
  logic                line1_v_r, line1_v_s;
  logic                discard_r, discard_s;
  logic                req_r, req_s;
  logic [25:0]         adr_r, adr_s;
  logic                al_v_r, al_v_s;
  logic [2*LINE_W-1:0] al_window_r;
  logic [31:0]         al_ip_r;
  logic [5:0]          al_ofs_r;

  logic                ack_s;
  logic [3:0]          len_s;
  logic [31:0]         nip_s;
  logic                cross_s;
  logic                adv_s;

  // Lengths outside 1..8 are clamped into range.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    logic [3:0] res;
    if (len == 4'd0) begin
      res = 4'd1;
    end else if (len > 4'd8) begin
      res = 4'd8;
    end else begin
      res = len;
    end
    return res;
  endfunction

  assign ack_s   = req_r & ic_ack_i;
  assign len_s   = clamp_len(al_len_i);
  assign nip_s   = ip_r + {28'd0, len_s};
  assign cross_s = (({1'b0, ip_r[5:0]} + {3'b000, len_s}) >= 7'd64);
  assign adv_s   = al_v_r & al_rdy_i;

  // Next state for IP, line buffers and the discard flag; redirect wins over advance and ack.
  always_comb begin
    state_s   = state_r;
    ip_s      = ip_r;
    line0_s   = line0_r;
    line1_s   = line1_r;
    line0_v_s = line0_v_r;
    line1_v_s = line1_v_r;
    discard_s = discard_r;
    if (redirect_i) begin
      ip_s = redirect_ip_i;
      if (discard_r) begin
        discard_s = ~ack_s;
      end else begin
        state_s   = FETCH0;
        line0_v_s = 1'b0;
        line1_v_s = 1'b0;
        discard_s = req_r & ~ic_ack_i;
      end
    end else if (discard_r) begin
      // The stale line returning here belongs to the pre-redirect stream.
      discard_s = ~ack_s;
    end else begin
      case (state_r)
        FETCH0: begin
          if (ack_s) begin
            line0_s   = ic_line_i;
            line0_v_s = 1'b1;
            state_s   = FETCH1;
          end else begin
            state_s = FETCH0;
          end
        end
        FETCH1: begin
          if (ack_s) begin
            line1_s   = ic_line_i;
            line1_v_s = 1'b1;
            state_s   = RUN;
          end else begin
            state_s = FETCH1;
          end
        end
        RUN: begin
          if (adv_s) begin
            ip_s = nip_s;
            if (cross_s) begin
              line0_s   = line1_r;
              line1_v_s = 1'b0;
            end else begin
              line1_v_s = line1_v_r;
            end
          end else if (ack_s) begin
            line1_s   = ic_line_i;
            line1_v_s = 1'b1;
          end else begin
            state_s = RUN;
          end
        end
        default: begin
          state_s   = FETCH0;
          line0_v_s = 1'b0;
          line1_v_s = 1'b0;
        end
      endcase
    end
  end

  // Request and aligner-visible outputs, derived from the next state so they are registered.
  always_comb begin
    req_s  = req_r;
    adr_s  = adr_r;
    al_v_s = 1'b0;
    if (req_r && !ic_ack_i) begin
      req_s = 1'b1;
      adr_s = adr_r;
    end else begin
      req_s = (state_s != RUN) || !line1_v_s;
      if (!req_s) begin
        adr_s = adr_r;
      end else if (state_s == FETCH0) begin
        adr_s = ip_s[31:6];
      end else begin
        adr_s = ip_s[31:6] + 26'd1;
      end
    end
    al_v_s = (state_s == RUN) && line0_v_s && line1_v_s && !discard_s;
  end

  // State register; window/IP outputs only refresh while the window is valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= FETCH0;
      ip_r        <= RESET_IP;
      line0_r     <= '0;
      line1_r     <= '0;
      line0_v_r   <= 1'b0;
      line1_v_r   <= 1'b0;
      discard_r   <= 1'b0;
      req_r       <= 1'b0;
      adr_r       <= 26'd0;
      al_v_r      <= 1'b0;
      al_window_r <= '0;
      al_ip_r     <= RESET_IP;
      al_ofs_r    <= 6'd0;
    end else begin
      state_r   <= state_s;
      ip_r      <= ip_s;
      line0_r   <= line0_s;
      line1_r   <= line1_s;
      line0_v_r <= line0_v_s;
      line1_v_r <= line1_v_s;
      discard_r <= discard_s;
      req_r     <= req_s;
      adr_r     <= adr_s;
      al_v_r    <= al_v_s;
      if (al_v_s) begin
        al_window_r <= {line1_s, line0_s};
        al_ip_r     <= ip_s;
        al_ofs_r    <= ip_s[5:0];
      end else begin
        al_window_r <= al_window_r;
        al_ip_r     <= al_ip_r;
        al_ofs_r    <= al_ofs_r;
      end
    end
  end

  assign ic_req_o    = req_r;
  assign ic_adr_o    = adr_r;
  assign al_v_o      = al_v_r;
  assign al_window_o = al_window_r;
  assign al_ip_o     = al_ip_r;
  assign al_ofs_o    = al_ofs_r;

endmodule

// File: tb/tb_any1_fetch_seq.sv
// Bench for any1_fetch_seq: a responsive I-cache model plus an architectural IP/window
// model compared every cycle, with directed scenarios and literal checkpoints.
module tb_any1_fetch_seq;
  localparam int LW = 512;
  localparam logic [31:0] RIP = 32'hFFFC0000;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          redirect_i = 1'b0;
  logic [31:0]   redirect_ip_i = 32'd0;
  logic          ic_req_o;
  logic [25:0]   ic_adr_o;
  logic          ic_ack_i = 1'b0;
  logic [LW-1:0] ic_line_i = '0;
  logic          al_v_o;
  logic [2*LW-1:0] al_window_o;
  logic [31:0]   al_ip_o;
  logic [5:0]    al_ofs_o;
  logic [3:0]    al_len_i = 4'd1;
  logic          al_rdy_i = 1'b0;

  int total = 0;
  int bad = 0;
  int age = 0;
  int dly = 2;

  any1_fetch_seq #(.RESET_IP(RIP), .LINE_W(LW)) dut (
    .rst_i(rst_i), .clk_i(clk_i), .redirect_i(redirect_i), .redirect_ip_i(redirect_ip_i),
    .ic_req_o(ic_req_o), .ic_adr_o(ic_adr_o), .ic_ack_i(ic_ack_i), .ic_line_i(ic_line_i),
    .al_v_o(al_v_o), .al_window_o(al_window_o), .al_ip_o(al_ip_o), .al_ofs_o(al_ofs_o),
    .al_len_i(al_len_i), .al_rdy_i(al_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory contents: every 32-bit word tags its own line address and word index.
  function automatic logic [LW-1:0] mem_line(input logic [25:0] a);
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = {a, 6'(k)};
    return l;
  endfunction

  function automatic logic [3:0] clamp(input logic [3:0] l);
    if (l == 4'd0) return 4'd1;
    else if (l > 4'd8) return 4'd8;
    else return l;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Architectural model state
  logic [31:0]   m_ip;
  logic [25:0]   fetched[$];
  logic [25:0]   req_log[$];
  logic          stale, redir_last, prev_req, prev_ack, prev_al_v;
  logic [25:0]   prev_adr;
  logic [31:0]   prev_al_ip;
  logic [2*LW-1:0] prev_win;

  function automatic bit have(input logic [25:0] a);
    for (int i = 0; i < fetched.size(); i++) if (fetched[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Compare process: check outputs, then apply the events that take effect at the next edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        m_ip = RIP; fetched.delete(); stale = 1'b0; redir_last = 1'b0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_al_v = 1'b1;
      end else begin
        if (prev_req && !prev_ack) begin
          chk("hs_req_held", ic_req_o, 1);
          chk("hs_adr_stable", ic_adr_o, prev_adr);
        end
        if (ic_req_o && (!prev_req || prev_ack)) begin
          req_log.push_back(ic_adr_o);
          chk("req_adr_target", (ic_adr_o == m_ip[31:6]) || (ic_adr_o == m_ip[31:6] + 26'd1), 1);
        end
        if (redir_last) chk("alv_after_redirect", al_v_o, 0);
        if (al_v_o) begin
          chk("al_ip", al_ip_o, m_ip);
          chk("al_ofs", al_ofs_o, m_ip[5:0]);
          chk("window", al_window_o == {mem_line(m_ip[31:6] + 26'd1), mem_line(m_ip[31:6])}, 1);
          chk("lines_fetched", have(m_ip[31:6]) && have(m_ip[31:6] + 26'd1), 1);
        end else if (!prev_al_v) begin
          chk("hold_ip", al_ip_o, prev_al_ip);
          chk("hold_win", al_window_o == prev_win, 1);
        end
        redir_last = redirect_i;
        if (redirect_i) begin
          m_ip = redirect_ip_i;
          fetched.delete();
          stale = ic_req_o && !ic_ack_i;
        end else begin
          if (ic_req_o && ic_ack_i) begin
            if (!stale) fetched.push_back(ic_adr_o);
            stale = 1'b0;
          end
          if (al_v_o && al_rdy_i) m_ip = m_ip + {28'd0, clamp(al_len_i)};
        end
        prev_req = ic_req_o; prev_ack = ic_ack_i; prev_adr = ic_adr_o;
        prev_al_v = al_v_o; prev_al_ip = al_ip_o; prev_win = al_window_o;
      end
    end
  end

  // One clock; the cache model acks a request in its dly-th cycle.
  task automatic tick();
    @(posedge clk_i); #1;
    if (rst_i) begin
      ic_ack_i = 1'b0; age = 0;
    end else begin
      if (ic_ack_i) begin ic_ack_i = 1'b0; age = 0; end
      if (ic_req_o) begin
        age++;
        if (age >= dly) begin ic_ack_i = 1'b1; ic_line_i = mem_line(ic_adr_o); end
      end
    end
  endtask

  task automatic wait_v(output logic [31:0] ip, output logic [5:0] ofs);
    int n = 0;
    while (!al_v_o && n < 300) begin tick(); n++; end
    if (!al_v_o) begin
      total++; bad++;
      $display("FAIL wait_alv: al_v_o got 0 required 1 within 300 cycles");
    end
    ip = al_ip_o; ofs = al_ofs_o;
  endtask

  task automatic consume(input logic [3:0] len, output logic [31:0] ip);
    logic [5:0] o;
    wait_v(ip, o);
    al_rdy_i = 1'b1; al_len_i = len;
    tick();
    al_rdy_i = 1'b0;
  endtask

  task automatic wait_req(input logic [25:0] a);
    int n = 0;
    while (!(ic_req_o && ic_adr_o == a) && n < 300) begin tick(); n++; end
    chk("wait_req_adr", ic_adr_o, a);
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_i = 1'b1; redirect_ip_i = tgt;
    tick();
    redirect_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ip;
    logic [5:0]  ofs;
    logic [3:0]  lens [8] = '{4'd15, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd0, 4'd1};
    int n;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_req", ic_req_o, 0);
    chk("rst_adr", ic_adr_o, 26'h0);
    chk("rst_alv", al_v_o, 0);
    rst_i = 1'b0;

    // Cold start
    tick();
    chk("cold_req_rise", ic_req_o, 1);
    chk("cold_adr0", ic_adr_o, 26'h3FFF000);
    wait_v(ip, ofs);
    chk("cold_ip", ip, 32'hFFFC0000);
    chk("cold_ofs", ofs, 6'd0);
    chk("cold_req_count", req_log.size(), 2);
    chk("cold_adr1", req_log[1], 26'h3FFF001);

    // Sequential steps
    consume(4'd4, ip); chk("seq_ip0", ip, 32'hFFFC0000);
    consume(4'd4, ip); chk("seq_ip1", ip, 32'hFFFC0004);
    consume(4'd2, ip); chk("seq_ip2", ip, 32'hFFFC0008);
    wait_v(ip, ofs);   chk("seq_ip3", ip, 32'hFFFC000A);
    chk("seq_no_req", req_log.size(), 2);

    // Walk to offset 0x3C with clamped lengths, then cross the line
    for (int i = 0; i < 8; i++) consume(lens[i], ip);
    consume(4'd5, ip);
    chk("cross_from_ip", ip, 32'hFFFC003C);
    chk("cross_alv_low", al_v_o, 0);
    chk("cross_req", ic_req_o, 1);
    chk("cross_adr", ic_adr_o, 26'h3FFF002);
    wait_v(ip, ofs);
    chk("cross_ip", ip, 32'hFFFC0041);
    chk("cross_ofs", ofs, 6'd1);
    chk("cross_line0", al_window_o[LW-1:0] == mem_line(26'h3FFF001), 1);

    // Redirect while the next line request is outstanding
    for (int i = 0; i < 7; i++) consume(4'd8, ip);
    consume(4'd5, ip);
    consume(4'd8, ip);
    chk("pend_from_ip", ip, 32'hFFFC007E);
    chk("pend_outstanding", ic_req_o && !ic_ack_i, 1);
    do_redirect(32'h00001000);
    wait_v(ip, ofs);
    chk("redir_ip", ip, 32'h00001000);
    chk("redir_adr_f0", req_log[$-1], 26'h40);
    chk("redir_adr_f1", req_log[$], 26'h41);
    chk("redir_line0", al_window_o[LW-1:0] == mem_line(26'h40), 1);

    // Straddle: target at offset 62 must wait for both lines
    do_redirect(32'h0000203E);
    wait_req(26'h81);
    chk("straddle_hold", al_v_o, 0);
    consume(4'd8, ip);
    chk("straddle_ip", ip, 32'h0000203E);
    chk("straddle_next_adr", ic_adr_o, 26'h82);

    // Redirect coinciding with the ack
    n = 0;
    while (!ic_ack_i && n < 50) begin tick(); n++; end
    chk("coinc_ack_seen", ic_ack_i, 1);
    do_redirect(32'h00003000);
    chk("coinc_req", ic_req_o, 1);
    chk("coinc_adr", ic_adr_o, 26'hC0);
    wait_v(ip, ofs);
    chk("coinc_ip", ip, 32'h00003000);

    // Asynchronous reset pulse while in FETCH1
    do_redirect(32'h00004010);
    wait_req(26'h101);
    #2;
    rst_i = 1'b1;
    ic_ack_i = 1'b0; age = 0;
    #1;
    chk("mr_req", ic_req_o, 0);
    chk("mr_adr", ic_adr_o, 26'h0);
    chk("mr_alv", al_v_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    wait_v(ip, ofs);
    chk("restart_ip", ip, RIP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
